// File: rtl/alu_mc_if.sv
// alu_mc request/result bus: request side (start/ctl/a/b) and result side
// (ready/valid/out/zero/ovf) grouped for the multi-cycle ALU.
interface alu_mc_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [3:0]       ctl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             ovf;

  modport master (
    output start, ctl, a, b,
    input  ready, valid, out, zero, ovf
  );

  modport slave (
    input  start, ctl, a, b,
    output ready, valid, out, zero, ovf
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU. Single-cycle logic/arith ops, shift-add multiply
// (WIDTH cycles) and, when ALU_MC_DIV_EN is defined, a restoring divider
// (WIDTH cycles) for divu/remu. All outputs are registered.
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic   clk,
  input  logic   rst_n,
  alu_mc_if.slave bus
);

  localparam int unsigned CW  = $clog2(WIDTH + 1);
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
`ifdef ALU_MC_DIV_EN
  localparam logic [1:0] DIV  = 2'd2;
`endif
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
`ifdef ALU_MC_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'd10;
  localparam logic [3:0] OP_REMU = 4'd11;
`endif
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_XOR  = 4'd13;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;      // multiplicand / dividend-quotient
  logic [WIDTH-1:0] y_q, y_d;      // multiplier / divisor
  logic [WIDTH-1:0] acc_q, acc_d;  // product / partial remainder
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
`ifdef ALU_MC_DIV_EN
  logic             rem_q, rem_d;
  logic [WIDTH:0]   r_shift_c, r_diff_c;
  logic             r_ok_c;
  logic [WIDTH-1:0] rem_nx_c, quo_nx_c, div_res_c;
`endif

  logic [WIDTH-1:0] sum_c, dif_c, alu_res_c, mul_acc_c;
  logic             add_ovf_c, sub_ovf_c, alu_ovf_c, accept_c;

  assign bus.ready = ready_q;
  assign bus.valid = valid_q;
  assign bus.out   = out_q;
  assign bus.zero  = zero_q;
  assign bus.ovf   = ovf_q;

  // Single-cycle operations, including the overflow-correct signed compare
  always_comb begin
    sum_c     = bus.a + bus.b;
    dif_c     = bus.a - bus.b;
    add_ovf_c = (bus.a[MSB] == bus.b[MSB]) && (sum_c[MSB] != bus.a[MSB]);
    sub_ovf_c = (bus.a[MSB] != bus.b[MSB]) && (dif_c[MSB] != bus.a[MSB]);
    alu_res_c = '0;
    alu_ovf_c = 1'b0;
    case (bus.ctl)
      OP_ADD:  begin alu_res_c = sum_c; alu_ovf_c = add_ovf_c; end
      OP_SUB:  begin alu_res_c = dif_c; alu_ovf_c = sub_ovf_c; end
      OP_AND:  alu_res_c = bus.a & bus.b;
      OP_OR:   alu_res_c = bus.a | bus.b;
      OP_NOR:  alu_res_c = ~(bus.a | bus.b);
      OP_XOR:  alu_res_c = bus.a ^ bus.b;
      OP_SLT:  alu_res_c = WIDTH'(dif_c[MSB] ^ sub_ovf_c);
      OP_SLTU: alu_res_c = WIDTH'(bus.a < bus.b);
      default: alu_res_c = '0;
    endcase
  end

`ifdef ALU_MC_DIV_EN
  // One restoring-division step; a zero divisor naturally yields all-ones / a
  always_comb begin
    r_shift_c = {acc_q, x_q[MSB]};
    r_diff_c  = r_shift_c - {1'b0, y_q};
    r_ok_c    = ~r_diff_c[WIDTH];
    rem_nx_c  = r_ok_c ? r_diff_c[WIDTH-1:0] : r_shift_c[WIDTH-1:0];
    quo_nx_c  = {x_q[WIDTH-2:0], r_ok_c};
    div_res_c = rem_q ? rem_nx_c : quo_nx_c;
  end
`endif

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
`ifdef ALU_MC_DIV_EN
    rem_d     = rem_q;
`endif
    accept_c  = ready_q & bus.start;
    mul_acc_c = acc_q + (y_q[0] ? x_q : '0);

    case (state_q)
      MUL: begin
        acc_d = mul_acc_c;
        x_d   = x_q << 1;
        y_d   = y_q >> 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(0)) begin
          state_d = DONE;
          out_d   = mul_acc_c;
          zero_d  = (mul_acc_c == '0);
          ovf_d   = 1'b0;
        end
      end
`ifdef ALU_MC_DIV_EN
      DIV: begin
        acc_d = rem_nx_c;
        x_d   = quo_nx_c;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(0)) begin
          state_d = DONE;
          out_d   = div_res_c;
          zero_d  = (div_res_c == '0);
          ovf_d   = 1'b0;
        end
      end
`endif
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept_c) begin
          case (bus.ctl)
            OP_MUL: begin
              state_d = MUL;
              x_d     = bus.a;
              y_d     = bus.b;
              acc_d   = '0;
              cnt_d   = CW'(WIDTH - 1);
            end
`ifdef ALU_MC_DIV_EN
            OP_DIVU, OP_REMU: begin
              state_d = DIV;
              x_d     = bus.a;
              y_d     = bus.b;
              acc_d   = '0;
              cnt_d   = CW'(WIDTH - 1);
              rem_d   = (bus.ctl == OP_REMU);
            end
`endif
            default: begin
              state_d = DONE;
              out_d   = alu_res_c;
              zero_d  = (alu_res_c == '0);
              ovf_d   = alu_ovf_c;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE) || (state_d == DONE);
    valid_d = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
`ifdef ALU_MC_DIV_EN
      rem_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
`ifdef ALU_MC_DIV_EN
      rem_q   <= rem_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Testbench for alu_mc (WIDTH=32): directed vectors plus random operations
// checked against an arithmetic reference model. Honours ALU_MC_DIV_EN.
module tb_alu_mc;

  localparam int unsigned W = 32;
  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: result, overflow flag and latency straight from the op definitions
  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic o, output int lat);
    int sa, sb;
    longint s;
    logic [63:0] p;
    sa = a; sb = b;
    r = 32'h0; o = 1'b0; lat = 1;
    case (c)
      4'd2:  begin s = longint'(sa) + longint'(sb); r = a + b; o = (s > MAXI) || (s < MINI); end
      4'd6:  begin s = longint'(sa) - longint'(sb); r = a - b; o = (s > MAXI) || (s < MINI); end
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd12: r = ~(a | b);
      4'd13: r = a ^ b;
      4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd3:  r = (a < b) ? 32'd1 : 32'd0;
      4'd8:  begin p = 64'(a) * 64'(b); r = p[31:0]; lat = 33; end
`ifdef ALU_MC_DIV_EN
      4'd10: begin r = (b == 0) ? 32'hFFFF_FFFF : a / b; lat = 33; end
      4'd11: begin r = (b == 0) ? a : a % b; lat = 33; end
`endif
      default: r = 32'h0;
    endcase
  endfunction

  // Issue one request, wait (bounded) for valid, compare everything
  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input bit junk);
    logic [31:0] er;
    logic        eo;
    int          elat, lat;
    model(c, a, b, er, eo, elat);
    @(negedge clk);
    bus.start = 1'b1; bus.ctl = c; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    if (elat > 1) check({tag, "_busy_ready"}, 64'(bus.ready), 64'd0);
    while (!bus.valid && lat < 100) begin
      if (junk && lat < elat - 2) begin
        bus.start = 1'b1; bus.ctl = 4'($urandom); bus.a = $urandom; bus.b = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(elat));
    check({tag, "_out"}, 64'(bus.out), 64'(er));
    check({tag, "_zero"}, 64'(bus.zero), 64'(er == 32'h0));
    check({tag, "_ovf"}, 64'(bus.ovf), 64'(eo));
    check({tag, "_done_ready"}, 64'(bus.ready), 64'd1);
    @(negedge clk);
    check({tag, "_single_valid"}, 64'(bus.valid), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, er;
    logic [3:0]  rc;
    logic        eo;
    int          elat, lat;
    checks = 0; failures = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.ctl = 4'd0; bus.a = '0; bus.b = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_valid", 64'(bus.valid), 64'd0);
    check("rst_out",   64'(bus.out),   64'd0);
    check("rst_zero",  64'(bus.zero),  64'd1);
    check("rst_ovf",   64'(bus.ovf),   64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    run_op("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'd1, 1'b0);
    run_op("sub_zero", 4'd6, 32'd5, 32'd5, 1'b0);
    run_op("slt_neg", 4'd7, 32'h8000_0000, 32'd1, 1'b0);
    run_op("sltu_neg", 4'd3, 32'h8000_0000, 32'd1, 1'b0);
    run_op("slt_ovf", 4'd7, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    run_op("mul_busy", 4'd8, 32'h0000_FFFF, 32'h0001_0001, 1'b1);
    run_op("bad_code", 4'd15, 32'h1234, 32'h5678, 1'b0);
    run_op("divu", 4'd10, 32'd100, 32'd7, 1'b0);
    run_op("remu", 4'd11, 32'd100, 32'd7, 1'b0);
    run_op("divu_z", 4'd10, 32'd100, 32'd0, 1'b0);
    run_op("remu_z", 4'd11, 32'd9, 32'd0, 1'b0);

    // Back-to-back: xor then and with start held high
    @(negedge clk);
    bus.start = 1'b1; bus.ctl = 4'd13; bus.a = 32'hF0F0_F0F0; bus.b = 32'hFF00_FF00;
    @(negedge clk);
    check("b2b_xor_valid", 64'(bus.valid), 64'd1);
    check("b2b_xor_out", 64'(bus.out), 64'h0FF0_0FF0);
    bus.ctl = 4'd0; bus.a = 32'hF0F0_F0F0; bus.b = 32'hFF00_FF00;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_and_valid", 64'(bus.valid), 64'd1);
    check("b2b_and_out", 64'(bus.out), 64'hF000_F000);
    @(negedge clk);
    check("b2b_end_valid", 64'(bus.valid), 64'd0);

    // Reset in the middle of a multiply
    bus.start = 1'b1; bus.ctl = 4'd8; bus.a = 32'h1234_5678; bus.b = 32'h9ABC_DEF1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (lat < 10) begin
      check("mid_mul_novalid", 64'(bus.valid), 64'd0);
      @(negedge clk);
      lat++;
    end
    rst_n = 1'b0;
    #1;
    check("abort_ready", 64'(bus.ready), 64'd1);
    check("abort_valid", 64'(bus.valid), 64'd0);
    check("abort_out",   64'(bus.out),   64'd0);
    check("abort_zero",  64'(bus.zero),  64'd1);
    check("abort_ovf",   64'(bus.ovf),   64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.valid) check("post_abort_spurious_valid", 64'(bus.valid), 64'd0);
    end
    check("post_abort_out", 64'(bus.out), 64'd0);
    run_op("add_after_rst", 4'd2, 32'd2, 32'd3, 1'b0);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rc = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: ra = 32'h8000_0000;
        1: ra = 32'h7FFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rb = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 300));
        default: rb = $urandom;
      endcase
      model(rc, ra, rb, er, eo, elat);
      run_op($sformatf("rnd%0d_c%0d", i, rc), rc, ra, rb, elat > 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
